// File: rtl/hash_job_sched.sv
// hash_job_sched: sequences a micro_ucr_hash engine through a nonce search, one result per job.
// Define HASH_NONCE_LIMIT_EN to end each job after NONCE_LIMIT issued nonces.
module hash_job_sched #(
    parameter logic [31:0] NONCE_START  = 32'h01001733,
    parameter int unsigned MAX_INFLIGHT = 2,
    parameter logic [31:0] NONCE_LIMIT  = 32'h00010000
) (
    input  logic         clk,
    input  logic         active,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [95:0]  job_payload,
    input  logic [7:0]   job_target,
    output logic         hash_req_valid,
    input  logic         hash_req_ready,
    output logic [127:0] hash_bloque,
    input  logic         hash_rsp_valid,
    input  logic [23:0]  hash_rsp_hash,
    input  logic [31:0]  hash_rsp_nonce,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_found,
    output logic [31:0]  res_nonce,
    output logic [23:0]  res_hash,
    output logic [31:0]  res_count,
    output logic         busy
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [3:0] MAX_IF  = 4'(MAX_INFLIGHT);

    logic [1:0]  state_q, state_d;
    logic [95:0] payload_q, payload_d;
    logic [7:0]  target_q, target_d;
    logic [31:0] nonce_q, nonce_d;
    logic [31:0] issued_q, issued_d;
    logic [31:0] win_nonce_q, win_nonce_d;
    logic [23:0] win_hash_q, win_hash_d;
    logic        found_q, found_d;
    logic [3:0]  inflight_q, inflight_d;
    logic        limit_hit, rsp_take, rsp_hit, req_fire;

    function automatic logic qualifies(input logic [23:0] h, input logic [7:0] t);
        return (h[23:16] < t) && (h[15:8] < t);
    endfunction

`ifdef HASH_NONCE_LIMIT_EN
    assign limit_hit = (issued_q == NONCE_LIMIT);
`else
    logic unused_limit;
    assign limit_hit    = 1'b0;
    assign unused_limit = ^NONCE_LIMIT;
`endif

    // Stray responses (nothing outstanding, or outside RUN/DRAIN) are dropped entirely.
    assign rsp_take = hash_rsp_valid && (inflight_q != 4'd0) &&
                      ((state_q == S_RUN) || (state_q == S_DRAIN));
    assign rsp_hit  = rsp_take && (state_q == S_RUN) && qualifies(hash_rsp_hash, target_q);
    // A winner arriving this cycle also blocks this cycle's request.
    assign hash_req_valid = (state_q == S_RUN) && (inflight_q < MAX_IF) && !limit_hit && !rsp_hit;
    assign req_fire       = hash_req_valid && hash_req_ready;

    assign hash_bloque = {payload_q, nonce_q};
    assign job_ready   = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign res_valid   = (state_q == S_DONE);
    assign res_found   = found_q;
    assign res_nonce   = win_nonce_q;
    assign res_hash    = win_hash_q;
    assign res_count   = issued_q;

    always_comb begin
        state_d     = state_q;
        payload_d   = payload_q;
        target_d    = target_q;
        nonce_d     = nonce_q;
        issued_d    = issued_q;
        win_nonce_d = win_nonce_q;
        win_hash_d  = win_hash_q;
        found_d     = found_q;
        inflight_d  = inflight_q + 4'(req_fire) - 4'(rsp_take);
        if (req_fire) begin
            nonce_d  = nonce_q + 32'd1;
            issued_d = issued_q + 32'd1;
        end
        case (state_q)
            S_IDLE: begin
                if (job_valid) begin
                    payload_d   = job_payload;
                    target_d    = job_target;
                    nonce_d     = NONCE_START;
                    issued_d    = 32'd0;
                    inflight_d  = 4'd0;
                    found_d     = 1'b0;
                    win_nonce_d = 32'd0;
                    win_hash_d  = 24'd0;
                    state_d     = S_RUN;
                end
            end
            S_RUN: begin
                if (rsp_hit) begin
                    found_d     = 1'b1;
                    win_nonce_d = hash_rsp_nonce;
                    win_hash_d  = hash_rsp_hash;
                    state_d     = S_DRAIN;
                end else if (limit_hit) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (inflight_d == 4'd0) state_d = S_DONE;
            end
            default: begin
                if (res_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge active) begin
        if (!active) begin
            state_q     <= S_IDLE;
            payload_q   <= 96'd0;
            target_q    <= 8'd0;
            nonce_q     <= 32'd0;
            issued_q    <= 32'd0;
            win_nonce_q <= 32'd0;
            win_hash_q  <= 24'd0;
            found_q     <= 1'b0;
            inflight_q  <= 4'd0;
        end else begin
            state_q     <= state_d;
            payload_q   <= payload_d;
            target_q    <= target_d;
            nonce_q     <= nonce_d;
            issued_q    <= issued_d;
            win_nonce_q <= win_nonce_d;
            win_hash_q  <= win_hash_d;
            found_q     <= found_d;
            inflight_q  <= inflight_d;
        end
    end
endmodule

// File: tb/tb_hash_job_sched.sv
// Scoreboard bench for hash_job_sched: two instances (default start, and start 32'hfffffffe / limit 8).
module tb_hash_job_sched;
    localparam logic [31:0] S0   = 32'h01001733;
    localparam logic [31:0] S1   = 32'hfffffffe;
    localparam logic [31:0] NONE = 32'h80000000;

    typedef struct packed {
        logic        g;
        logic        found;
        logic [31:0] nonce;
        logic [23:0] hash;
        logic [31:0] count;
        logic [31:0] last;
    } exp_t;

    logic clk = 1'b0;
    logic active = 1'b0;
    always #5 clk = ~clk;

    logic         job_valid      [2];
    logic         job_ready      [2];
    logic [95:0]  job_payload    [2];
    logic [7:0]   job_target     [2];
    logic         hash_req_valid [2];
    logic         hash_req_ready [2];
    logic [127:0] hash_bloque    [2];
    logic         hash_rsp_valid [2];
    logic [23:0]  hash_rsp_hash  [2];
    logic [31:0]  hash_rsp_nonce [2];
    logic         res_valid      [2];
    logic         res_ready      [2];
    logic         res_found      [2];
    logic [31:0]  res_nonce      [2];
    logic [23:0]  res_hash       [2];
    logic [31:0]  res_count      [2];
    logic         busy           [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        hash_job_sched #(
            .NONCE_START (g == 0 ? S0 : S1),
            .MAX_INFLIGHT(2),
            .NONCE_LIMIT (g == 0 ? 32'h00010000 : 32'd8)
        ) u_dut (
            .clk           (clk),
            .active        (active),
            .job_valid     (job_valid[g]),
            .job_ready     (job_ready[g]),
            .job_payload   (job_payload[g]),
            .job_target    (job_target[g]),
            .hash_req_valid(hash_req_valid[g]),
            .hash_req_ready(hash_req_ready[g]),
            .hash_bloque   (hash_bloque[g]),
            .hash_rsp_valid(hash_rsp_valid[g]),
            .hash_rsp_hash (hash_rsp_hash[g]),
            .hash_rsp_nonce(hash_rsp_nonce[g]),
            .res_valid     (res_valid[g]),
            .res_ready     (res_ready[g]),
            .res_found     (res_found[g]),
            .res_nonce     (res_nonce[g]),
            .res_hash      (res_hash[g]),
            .res_count     (res_count[g]),
            .busy          (busy[g])
        );
    end

    // Engine model: 2-cycle latency, in-order; winners hash to {05,07,nonce[7:0]}.
    logic [31:0] win_a [2];
    logic [31:0] win_b [2];
    logic        s1_v  [2];
    logic        s2_v  [2];
    logic [31:0] s1_n  [2];
    logic [31:0] s2_n  [2];

    function automatic logic [23:0] model_hash(input logic [31:0] n, input logic [31:0] wa,
                                               input logic [31:0] wb);
        if (n == wa || n == wb) return {8'h05, 8'h07, n[7:0]};
        return n[0] ? 24'h033000 : 24'h300300;
    endfunction

    always @(posedge clk or negedge active) begin
        for (int g = 0; g < 2; g++) begin
            if (!active) begin
                s1_v[g] <= 1'b0;
                s2_v[g] <= 1'b0;
                s1_n[g] <= 32'd0;
                s2_n[g] <= 32'd0;
            end else begin
                s1_v[g] <= hash_req_valid[g] && hash_req_ready[g];
                s1_n[g] <= hash_bloque[g][31:0];
                s2_v[g] <= s1_v[g];
                s2_n[g] <= s1_n[g];
            end
        end
    end

    always_comb begin
        for (int g = 0; g < 2; g++) begin
            hash_rsp_valid[g] = s2_v[g];
            hash_rsp_nonce[g] = s2_n[g];
            hash_rsp_hash[g]  = model_hash(s2_n[g], win_a[g], win_b[g]);
        end
    end

    int          tests = 0;
    int          fails = 0;
    int          res_done = 0;
    exp_t        expq [$];
    exp_t        e;
    int          outst  [2] = '{0, 0};
    logic [31:0] exp_n  [2];
    logic [95:0] exp_pl [2];
    logic [31:0] last_n [2];
    logic        hold_v [2] = '{1'b0, 1'b0};
    logic [127:0] hold_b [2];
    logic        rv_prev [2] = '{1'b0, 1'b0};
    logic        rr_prev [2] = '{1'b0, 1'b0};
    logic [88:0] rprev   [2];

    task automatic chk(input string nm, input int g, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s[%0d]: got %0h expected %0h", nm, g, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (!active) begin
                chk("reset_outs", g,
                    256'({hash_req_valid[g], hash_bloque[g], res_valid[g], res_found[g], res_nonce[g],
                          res_hash[g], res_count[g], busy[g], job_ready[g]}),
                    256'({1'b0, 128'd0, 1'b0, 1'b0, 32'd0, 24'd0, 32'd0, 1'b0, 1'b1}));
                outst[g]   = 0;
                hold_v[g]  = 1'b0;
                rv_prev[g] = 1'b0;
                rr_prev[g] = 1'b0;
            end else begin
                if (job_valid[g] && job_ready[g]) begin
                    exp_n[g]  = (g == 0) ? S0 : S1;
                    exp_pl[g] = job_payload[g];
                end
                if (res_valid[g]) begin
                    if (!rv_prev[g]) chk("done_drained", g, 256'(outst[g]), 256'(0));
                    else if (!rr_prev[g])
                        chk("res_stable", g, 256'({res_found[g], res_nonce[g], res_hash[g], res_count[g]}),
                            256'(rprev[g]));
                    if (res_ready[g]) begin
                        if (expq.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL res_unexpected[%0d]: got result nonce %0h, required none", g, res_nonce[g]);
                        end else begin
                            e = expq.pop_front();
                            chk("res_inst", g, 256'(g), 256'(e.g));
                            chk("res_found", g, 256'(res_found[g]), 256'(e.found));
                            chk("res_nonce", g, 256'(res_nonce[g]), 256'(e.nonce));
                            chk("res_hash", g, 256'(res_hash[g]), 256'(e.hash));
                            chk("res_count", g, 256'(res_count[g]), 256'(e.count));
                            chk("last_issued", g, 256'(last_n[g]), 256'(e.last));
                            res_done++;
                        end
                    end
                end
                rv_prev[g] = res_valid[g];
                rr_prev[g] = res_ready[g];
                rprev[g]   = {res_found[g], res_nonce[g], res_hash[g], res_count[g]};
                if (hold_v[g] && hash_req_valid[g]) chk("hold_bloque", g, 256'(hash_bloque[g]), 256'(hold_b[g]));
                if (hash_req_valid[g] && hash_req_ready[g]) begin
                    chk("req_nonce", g, 256'(hash_bloque[g][31:0]), 256'(exp_n[g]));
                    chk("req_payload", g, 256'(hash_bloque[g][127:32]), 256'(exp_pl[g]));
                    chk("inflight_below_max", g, 256'(outst[g] < 2), 256'(1));
                    chk("busy_in_run", g, 256'({busy[g], job_ready[g]}), 256'(2'b10));
                    last_n[g] = hash_bloque[g][31:0];
                    exp_n[g]  = exp_n[g] + 32'd1;
                    outst[g]  = outst[g] + 1;
                end
                if (hash_rsp_valid[g] && outst[g] > 0) outst[g] = outst[g] - 1;
                hold_v[g] = hash_req_valid[g] && !hash_req_ready[g];
                hold_b[g] = hash_bloque[g];
            end
        end
    end

    task automatic run_job(input int g, input logic [95:0] pl, input logic [7:0] tg,
                           input logic [31:0] wa, input logic [31:0] wb, input int bp, input int rr_hold,
                           input logic found, input logic [31:0] nonce, input logic [23:0] hash,
                           input logic [31:0] count, input logic [31:0] last);
        exp_t x;
        int   d0;
        int   n;
        d0 = res_done;
        x.g = g[0]; x.found = found; x.nonce = nonce; x.hash = hash; x.count = count; x.last = last;
        expq.push_back(x);
        win_a[g] = wa;
        win_b[g] = wb;
        n = 0;
        while (!job_ready[g] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!job_ready[g]) begin
            $display("FAIL job_accept_timeout[%0d]: job_ready stayed 0, required 1", g);
            $fatal(1, "job acceptance timed out");
        end
        if (bp > 0) hash_req_ready[g] = 1'b0;
        if (rr_hold > 0) res_ready[g] = 1'b0;
        job_payload[g] = pl;
        job_target[g]  = tg;
        job_valid[g]   = 1'b1;
        @(posedge clk); #1;
        job_valid[g] = 1'b0;
        if (bp > 0) begin
            repeat (bp) @(posedge clk);
            #1 hash_req_ready[g] = 1'b1;
        end
        if (rr_hold > 0) begin
            n = 0;
            while (!res_valid[g] && n < 300) begin
                @(posedge clk); #1; n++;
            end
            repeat (rr_hold) @(posedge clk);
            #1 res_ready[g] = 1'b1;
        end
        n = 0;
        while (res_done == d0 && n < 300) begin
            @(posedge clk); #1; n++;
        end
        if (res_done == d0) begin
            $display("FAIL result_timeout[%0d]: no result handshake within 300 cycles", g);
            $fatal(1, "result timed out");
        end
    endtask

    initial begin
        for (int g = 0; g < 2; g++) begin
            job_valid[g]      = 1'b0;
            job_payload[g]    = 96'd0;
            job_target[g]     = 8'd0;
            hash_req_ready[g] = 1'b1;
            res_ready[g]      = 1'b1;
            win_a[g]          = NONE;
            win_b[g]          = NONE;
        end
        active = 1'b0;
        repeat (3) @(posedge clk);
        #1 active = 1'b1;

        run_job(0, 96'h0, 8'h10, 32'h01001740, NONE, 0, 0,
                1'b1, 32'h01001740, 24'h050740, 32'd14, 32'h01001740);
        run_job(0, 96'ha5a5a5a5_5a5a5a5a_c3c3c3c3, 8'h10, 32'h01001738, NONE, 5, 0,
                1'b1, 32'h01001738, 24'h050738, 32'd6, 32'h01001738);
        run_job(0, 96'h01234567_89abcdef_00112233, 8'h10, 32'h01001735, 32'h01001736, 0, 3,
                1'b1, 32'h01001735, 24'h050735, 32'd4, 32'h01001736);

        // Abort a running job with a one-cycle reset pulse, then run a fresh job.
        win_a[0]       = NONE;
        win_b[0]       = NONE;
        job_payload[0] = 96'hdead;
        job_target[0]  = 8'h10;
        job_valid[0]   = 1'b1;
        @(posedge clk); #1;
        job_valid[0] = 1'b0;
        repeat (6) @(posedge clk);
        #1 active = 1'b0;
        @(posedge clk);
        #1 active = 1'b1;
        run_job(0, 96'hfeed, 8'h10, 32'h01001734, NONE, 0, 0,
                1'b1, 32'h01001734, 24'h050734, 32'd2, 32'h01001734);

`ifdef HASH_NONCE_LIMIT_EN
        run_job(1, 96'h0badc0de, 8'h00, 32'h00000000, NONE, 0, 0,
                1'b0, 32'd0, 24'd0, 32'd8, 32'h00000005);
`else
        run_job(1, 96'h0badc0de, 8'h10, 32'h00000001, NONE, 0, 0,
                1'b1, 32'h00000001, 24'h050701, 32'd4, 32'h00000001);
`endif
        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
